// File: rtl/alu_seq_pkg.sv
// Shared types, encodings and flag helper for the 16-bit sequenced ALU wrapper.
package alu_seq_pkg;

  // Request opcodes; 5..7 are illegal.
  typedef enum logic [2:0] {
    OpAdd16 = 3'd0,
    OpSub16 = 3'd1,
    OpAnd16 = 3'd2,
    OpOr16  = 3'd3,
    OpXor16 = 3'd4
  } op_e;

  // Sequencer states.
  typedef logic [2:0] state_t;
  localparam state_t StIdle = 3'd0;
  localparam state_t StLo   = 3'd1;
  localparam state_t StHi   = 3'd2;
  localparam state_t StFix  = 3'd3;
  localparam state_t StDone = 3'd4;

  // 8-bit ALU mode and opcode encodings.
  localparam logic       ModeLogic = 1'b0;
  localparam logic       ModeArith = 1'b1;
  localparam logic [3:0] AluAdd    = 4'd1;
  localparam logic [3:0] AluSub    = 4'd3;
  localparam logic [3:0] AluInc    = 4'd9;
  localparam logic [3:0] AluDec    = 4'd10;
  localparam logic [3:0] AluAnd    = 4'd1;
  localparam logic [3:0] AluOr     = 4'd2;
  localparam logic [3:0] AluXor    = 4'd4;

  // Bit positions inside out_flags = {V,S,C,Z}.
  localparam int unsigned FlagZ = 0;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagS = 2;
  localparam int unsigned FlagV = 3;

  function automatic logic is_legal(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OpAdd16) || (op == OpSub16);
  endfunction

  // Returns {mode, opcode} for the per-byte pass of a 16-bit operation.
  function automatic logic [4:0] alu_enc(input logic [2:0] op);
    logic [4:0] enc;
    enc = 5'h00;
    case (op)
      OpAdd16: enc = {ModeArith, AluAdd};
      OpSub16: enc = {ModeArith, AluSub};
      OpAnd16: enc = {ModeLogic, AluAnd};
      OpOr16:  enc = {ModeLogic, AluOr};
      OpXor16: enc = {ModeLogic, AluXor};
      default: enc = 5'h00;
    endcase
    return enc;
  endfunction

  // Final {V,S,C,Z}; carry is a borrow for SUB16 and forced low for logic ops.
  function automatic logic [3:0] calc_flags(input logic [2:0]  op,
                                            input logic        a_msb,
                                            input logic        b_msb,
                                            input logic [15:0] res,
                                            input logic        carry);
    logic v;
    logic c;
    v = 1'b0;
    c = 1'b0;
    case (op)
      OpAdd16: begin
        v = (a_msb == b_msb) && (res[15] != a_msb);
        c = carry;
      end
      OpSub16: begin
        v = (a_msb != b_msb) && (res[15] != a_msb);
        c = carry;
      end
      default: begin
        v = 1'b0;
        c = 1'b0;
      end
    endcase
    return {v, res[15], c, (res == 16'h0000)};
  endfunction

endpackage

// File: rtl/alu_seq16.sv
// Sequences 16-bit ADD/SUB/AND/OR/XOR over an external 8-bit combinational ALU:
// low byte, high byte, then an optional INC/DEC pass to fold in the low-byte carry.
module alu_seq16
  import alu_seq_pkg::*;
#(
  parameter int unsigned CARRY_BIT = 4,
  parameter int unsigned ZERO_BIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [3:0]  out_flags,
  output logic        out_err,
  output logic        alu_mode,
  output logic        alu_en,
  output logic        alu_imm,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_i,
  input  logic [7:0]  alu_result,
  input  logic [7:0]  alu_flags
);

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [7:0]  res_lo_q, res_lo_d;
  logic [7:0]  res_hi_q, res_hi_d;
  logic        c_lo_q, c_lo_d;
  logic        c_hi_q, c_hi_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  flags_q, flags_d;
  logic        err_q, err_d;

  logic        alu_carry;
  logic        c_fix;
  logic [4:0]  enc;

  assign alu_carry = alu_flags[CARRY_BIT];

  // Only the carry bit of the ALU flags matters; Z is recomputed over 16 bits.
  logic unused_alu_flags;
  assign unused_alu_flags = ^{alu_flags, (ZERO_BIT == 0)};

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign out_err    = err_q;
  assign alu_imm    = 1'b0;
  assign alu_i      = 8'h00;

  // Next-state: request capture, per-byte result capture, carry fix-up, response.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    c_lo_d   = c_lo_q;
    c_hi_d   = c_hi_q;
    result_d = result_q;
    flags_d  = flags_q;
    err_d    = err_q;
    c_fix    = 1'b0;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = in_op;
          a_d  = in_a;
          b_d  = in_b;
          if (is_legal(in_op)) begin
            state_d = StLo;
          end else begin
            state_d  = StDone;
            result_d = 16'h0000;
            flags_d  = 4'h0;
            err_d    = 1'b1;
          end
        end
      end
      StLo: begin
        res_lo_d = alu_result;
        c_lo_d   = alu_carry;
        state_d  = StHi;
      end
      StHi: begin
        res_hi_d = alu_result;
        c_hi_d   = alu_carry;
        if (is_arith(op_q) && c_lo_q) begin
          state_d = StFix;
        end else begin
          state_d  = StDone;
          result_d = {alu_result, res_lo_q};
          flags_d  = calc_flags(op_q, a_q[15], b_q[15], {alu_result, res_lo_q}, alu_carry);
          err_d    = 1'b0;
        end
      end
      StFix: begin
        // The INC/DEC pass itself wraps only from 0xFF (INC) or 0x00 (DEC).
        c_fix    = (op_q == OpSub16) ? (res_hi_q == 8'h00) : (res_hi_q == 8'hFF);
        res_hi_d = alu_result;
        result_d = {alu_result, res_lo_q};
        flags_d  = calc_flags(op_q, a_q[15], b_q[15], {alu_result, res_lo_q},
                              c_hi_q | c_fix);
        err_d    = 1'b0;
        state_d  = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ALU drive: byte operands per pass, all zero while idle or responding.
  always_comb begin
    alu_en   = 1'b0;
    alu_mode = 1'b0;
    alu_op   = 4'h0;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    enc      = alu_enc(op_q);
    case (state_q)
      StLo: begin
        alu_en   = 1'b1;
        alu_mode = enc[4];
        alu_op   = enc[3:0];
        alu_a    = a_q[7:0];
        alu_b    = b_q[7:0];
      end
      StHi: begin
        alu_en   = 1'b1;
        alu_mode = enc[4];
        alu_op   = enc[3:0];
        alu_a    = a_q[15:8];
        alu_b    = b_q[15:8];
      end
      StFix: begin
        alu_en   = 1'b1;
        alu_mode = ModeArith;
        alu_op   = (op_q == OpSub16) ? AluDec : AluInc;
        alu_a    = res_hi_q;
        alu_b    = 8'h00;
      end
      default: begin
        alu_en = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= 3'd0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      res_lo_q <= 8'h00;
      res_hi_q <= 8'h00;
      c_lo_q   <= 1'b0;
      c_hi_q   <= 1'b0;
      result_q <= 16'h0000;
      flags_q  <= 4'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      c_lo_q   <= c_lo_d;
      c_hi_q   <= c_hi_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// Directed bench for alu_seq16 with a behavioural 8-bit ALU on the alu_* port.
module tb_alu_seq16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
  logic        out_err;
  logic        alu_mode;
  logic        alu_en;
  logic        alu_imm;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_i;
  logic [7:0]  alu_result;
  logic [7:0]  alu_flags;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [3:0]  f;    // {V,S,C,Z}
    int          lat;  // edges after the accept edge until out_valid is seen
  } vec_t;

  alu_seq16 #(
    .CARRY_BIT(4),
    .ZERO_BIT (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_flags (out_flags),
    .out_err   (out_err),
    .alu_mode  (alu_mode),
    .alu_en    (alu_en),
    .alu_imm   (alu_imm),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_i     (alu_i),
    .alu_result(alu_result),
    .alu_flags (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-bit ALU: bit 8 of m_sum is carry (ADD/INC) or borrow (SUB/DEC).
  logic [8:0] m_sum;
  always_comb begin
    m_sum = 9'h000;
    case ({alu_mode, alu_op})
      5'h11:   m_sum = {1'b0, alu_a} + {1'b0, alu_b};
      5'h13:   m_sum = {1'b0, alu_a} - {1'b0, alu_b};
      5'h19:   m_sum = {1'b0, alu_a} + 9'd1;
      5'h1A:   m_sum = {1'b0, alu_a} - 9'd1;
      5'h01:   m_sum = {1'b0, alu_a & alu_b};
      5'h02:   m_sum = {1'b0, alu_a | alu_b};
      5'h04:   m_sum = {1'b0, alu_a ^ alu_b};
      default: m_sum = 9'h000;
    endcase
  end
  assign alu_result = m_sum[7:0];
  assign alu_flags  = {3'b000, m_sum[8], 3'b000, (m_sum[7:0] == 8'h00)};

  // All driving and sampling happens 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request with out_ready high and reports what came back.
  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int lat, output logic [15:0] r, output logic [3:0] f,
                        output logic e);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    r = out_result;
    f = out_flags;
    e = out_err;
    tick();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = 16'h0;
    in_b      = 16'h0;
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    checks++;
    if (out_result !== 16'h0 || out_flags !== 4'h0 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: result=%h flags=%b err=%b want 0", out_result, out_flags,
               out_err);
    end
    checks++;
    if ({alu_en, alu_mode, alu_imm, alu_op, alu_a, alu_b, alu_i} !== 31'h0) begin
      errors++;
      $display("FAIL reset_alu: en=%b mode=%b imm=%b op=%h a=%h b=%h i=%h want 0", alu_en,
               alu_mode, alu_imm, alu_op, alu_a, alu_b, alu_i);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    vec_t        tbl [9];
    int          lat;
    logic [15:0] r;
    logic [3:0]  f;
    logic        e;
    tbl[0] = '{"add_00ff_1", 3'd0, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 3};
    tbl[1] = '{"add_ffff_1", 3'd0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 3};
    tbl[2] = '{"add_7fff_1", 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1100, 3};
    tbl[3] = '{"add_nofix",  3'd0, 16'h1234, 16'h0001, 16'h1235, 4'b0000, 2};
    tbl[4] = '{"add_8000x2", 3'd0, 16'h8000, 16'h8000, 16'h0000, 4'b1011, 2};
    tbl[5] = '{"sub_0100_1", 3'd1, 16'h0100, 16'h0001, 16'h00FF, 4'b0000, 3};
    tbl[6] = '{"sub_0000_1", 3'd1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0110, 3};
    tbl[7] = '{"sub_8000_1", 3'd1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000, 3};
    tbl[8] = '{"sub_nofix",  3'd1, 16'h5000, 16'h1000, 16'h4000, 4'b0000, 2};
    for (int i = 0; i < 9; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, r, f, e);
      checks++;
      if (r !== tbl[i].r || f !== tbl[i].f || e !== 1'b0) begin
        errors++;
        $display("FAIL %s: result=%h flags=%b err=%b want %h %b 0", tbl[i].name, r, f, e,
                 tbl[i].r, tbl[i].f);
      end
      checks++;
      if (lat != tbl[i].lat) begin
        errors++;
        $display("FAIL %s_lat: latency=%0d want %0d", tbl[i].name, lat, tbl[i].lat);
      end
    end
  endtask

  task automatic test_logic();
    vec_t        tbl [3];
    int          lat;
    logic [15:0] r;
    logic [3:0]  f;
    logic        e;
    tbl[0] = '{"and_f0f0", 3'd2, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000, 2};
    tbl[1] = '{"or_8000",  3'd3, 16'h8000, 16'h0001, 16'h8001, 4'b0100, 2};
    tbl[2] = '{"and_zero", 3'd2, 16'h00FF, 16'hFF00, 16'h0000, 4'b0001, 2};
    for (int i = 0; i < 3; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, r, f, e);
      checks++;
      if (r !== tbl[i].r || f !== tbl[i].f || e !== 1'b0 || lat != tbl[i].lat) begin
        errors++;
        $display("FAIL %s: result=%h flags=%b err=%b lat=%0d want %h %b 0 %0d", tbl[i].name,
                 r, f, e, lat, tbl[i].r, tbl[i].f, tbl[i].lat);
      end
    end
  endtask

  task automatic test_xor();
    in_valid  = 1'b1;
    in_op     = 3'd4;
    in_a      = 16'hA5A5;
    in_b      = 16'hFFFF;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({alu_en, alu_mode, alu_op, alu_a, alu_b, in_ready} !== {1'b1, 1'b0, 4'd4, 8'hA5,
                                                                8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL xor_lo: en=%b mode=%b op=%h a=%h b=%h rdy=%b want 1 0 4 a5 ff 0",
               alu_en, alu_mode, alu_op, alu_a, alu_b, in_ready);
    end
    tick();
    checks++;
    if ({alu_en, alu_mode, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, 4'd4, 8'hA5, 8'hFF}) begin
      errors++;
      $display("FAIL xor_hi: en=%b mode=%b op=%h a=%h b=%h want 1 0 4 a5 ff", alu_en,
               alu_mode, alu_op, alu_a, alu_b);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h5A5A || out_flags !== 4'b0000 ||
        alu_en !== 1'b0) begin
      errors++;
      $display("FAIL xor_done: valid=%b result=%h flags=%b en=%b want 1 5a5a 0000 0",
               out_valid, out_result, out_flags, alu_en);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL xor_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  // SUB16 0x0100-0x0001 walks LO, HI and the DEC fix-up pass.
  task automatic test_fix_drive();
    in_valid  = 1'b1;
    in_op     = 3'd1;
    in_a      = 16'h0100;
    in_b      = 16'h0001;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if ({alu_en, alu_mode, alu_op, alu_a, alu_b} !== {1'b1, 1'b1, 4'd3, 8'h00, 8'h01}) begin
      errors++;
      $display("FAIL sub_lo: en=%b mode=%b op=%h a=%h b=%h want 1 1 3 00 01", alu_en,
               alu_mode, alu_op, alu_a, alu_b);
    end
    tick();
    checks++;
    if ({alu_en, alu_mode, alu_op, alu_a, alu_b} !== {1'b1, 1'b1, 4'd3, 8'h01, 8'h00}) begin
      errors++;
      $display("FAIL sub_hi: en=%b mode=%b op=%h a=%h b=%h want 1 1 3 01 00", alu_en,
               alu_mode, alu_op, alu_a, alu_b);
    end
    tick();
    checks++;
    if ({alu_en, alu_mode, alu_op, alu_a, out_valid} !== {1'b1, 1'b1, 4'd10, 8'h01,
                                                          1'b0}) begin
      errors++;
      $display("FAIL sub_fix: en=%b mode=%b op=%h a=%h valid=%b want 1 1 a 01 0", alu_en,
               alu_mode, alu_op, alu_a, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h00FF || out_flags !== 4'b0000) begin
      errors++;
      $display("FAIL sub_fix_done: valid=%b result=%h flags=%b want 1 00ff 0000", out_valid,
               out_result, out_flags);
    end
    tick();
  endtask

  // Illegal opcode: response with err set in the cycle right after the accept.
  task automatic test_illegal();
    in_valid  = 1'b1;
    in_op     = 3'd7;
    in_a      = 16'h1234;
    in_b      = 16'h5678;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_err !== 1'b1 || out_result !== 16'h0 ||
        out_flags !== 4'h0 || alu_en !== 1'b0) begin
      errors++;
      $display("FAIL illegal: valid=%b err=%b result=%h flags=%b en=%b want 1 1 0 0 0",
               out_valid, out_err, out_result, out_flags, alu_en);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold();
    int wait_cnt;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_a      = 16'h7FFF;
    in_b      = 16'h0001;
    out_ready = 1'b0;
    tick();
    // A different request stays pending; it must not be taken while busy.
    in_op    = 3'd2;
    in_a     = 16'hFFFF;
    in_b     = 16'hFFFF;
    wait_cnt = 0;
    while (!out_valid && wait_cnt < 8) begin
      tick();
      wait_cnt++;
    end
    checks++;
    if (wait_cnt != 3) begin
      errors++;
      $display("FAIL hold_lat: latency=%0d want 3", wait_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== 16'h8000 ||
          out_flags !== 4'b1100 || out_err !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%b ready=%b result=%h flags=%b want 1 0 8000 1100", i,
                 out_valid, in_ready, out_result, out_flags);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    in_valid  = 1'b1;
    in_op     = 3'd2;
    in_a      = 16'hF0F0;
    in_b      = 16'h0FF0;
    out_ready = 1'b1;
    tick();
    in_op = 3'd3;
    in_a  = 16'h8000;
    in_b  = 16'h0001;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h00F0) begin
      errors++;
      $display("FAIL b2b_first: valid=%b result=%h want 1 00f0", out_valid, out_result);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || alu_en !== 1'b1 || alu_op !== 4'd2) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b en=%b op=%h want 0 1 2", in_ready, alu_en, alu_op);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_result !== 16'h8001 || out_flags !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_second: valid=%b result=%h flags=%b want 1 8001 0100", out_valid,
               out_result, out_flags);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int          seen;
    int          lat;
    logic [15:0] r;
    logic [3:0]  f;
    logic        e;
    in_valid  = 1'b1;
    in_op     = 3'd0;
    in_a      = 16'hFFFF;
    in_b      = 16'h0001;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (alu_en !== 1'b1 || alu_a !== 8'hFF) begin
      errors++;
      $display("FAIL rstmid_hi: en=%b a=%h want 1 ff", alu_en, alu_a);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_en !== 1'b0 ||
        out_result !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_idle: ready=%b valid=%b en=%b result=%h want 1 0 0 0", in_ready,
               out_valid, alu_en, out_result);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rstmid_noresp: out_valid cycles=%0d want 0", seen);
    end
    run_op(3'd4, 16'h1111, 16'h2222, lat, r, f, e);
    checks++;
    if (r !== 16'h3333 || f !== 4'b0000 || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL rstmid_after: result=%h flags=%b err=%b lat=%0d want 3333 0000 0 2", r,
               f, e, lat);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_xor();
    test_fix_drive();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq16.md
ALU_SEQ16 -- requirements
Module: alu_seq16

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst.
REQ-002 Parameter: CARRY_BIT, 4, index of carry in alu_flags.
REQ-003 Parameter: ZERO_BIT, 0, index of zero in alu_flags (informational; 16-bit Z is computed locally).
REQ-004 clk  in  1  clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  request valid; in_ready  out  1  sequencer can accept.
REQ-007 in_op  in  3  0=ADD16, 1=SUB16, 2=AND16, 3=OR16, 4=XOR16, 5..7 illegal.
REQ-008 in_a, in_b  in  16  operands.
REQ-009 out_valid  out  1; out_ready  in  1  response handshake.
REQ-010 out_result  out  16; out_flags  out  4  {V,S,C,Z}; out_err  out  1  illegal op.
REQ-011 alu_mode, alu_en, alu_imm  out  1 each; alu_op  out  4; alu_a, alu_b, alu_i  out  8  ALU drive.
REQ-012 alu_result  in  8; alu_flags  in  8  combinational ALU return.

Function
REQ-013 States SHALL be IDLE, LO, HI, FIX, DONE; in_ready = (state==IDLE).
REQ-014 Accept on in_valid&in_ready; latch op/a/b; legal op -> LO, illegal -> DONE with result 0, flags 0, out_err=1.
REQ-015 LO: alu_a=a[7:0], alu_b=b[7:0]; capture res_lo and c_lo=alu_flags[CARRY_BIT]; -> HI.
REQ-016 HI: alu_a=a[15:8], alu_b=b[15:8]; capture res_hi and c_hi; -> FIX if op in {ADD16,SUB16} and c_lo=1, else DONE.
REQ-017 ALU encodings: ADD mode1/op1, SUB mode1/op3, INC mode1/op9, DEC mode1/op10, AND mode0/op1, OR mode0/op2, XOR mode0/op4.
REQ-018 FIX: alu_a=res_hi, INC (ADD16) or DEC (SUB16); c_fix=1 iff res_hi was 0xFF (INC) or 0x00 (DEC); res_hi<=alu_result; -> DONE.
REQ-019 Final C = c_hi|c_fix for ADD16/SUB16 (C=borrow for SUB16); C=0 for logic ops.
REQ-020 Z = (result==0); S = result[15]; V: ADD16 (a15==b15)&(r15!=a15), SUB16 (a15!=b15)&(r15!=a15), logic 0.
REQ-021 DONE: out_valid=1, outputs stable until out_ready; on out_valid&out_ready -> IDLE, out_valid deasserts next cycle.
REQ-022 Latency accept-edge to out_valid: 2 cycles without FIX, 3 with FIX, 1 for illegal op.
REQ-023 alu_en=1 only in LO/HI/FIX; alu_imm=0, alu_i=0 always; alu_a/alu_b/alu_op/alu_mode=0 when idle.
REQ-024 No new request accepted while busy; back-to-back accept allowed the cycle after DONE handshake.

Reset
REQ-025 rst SHALL force IDLE, out_valid=0, out_result=0, out_flags=0, out_err=0, all alu_* outputs 0, internal latches 0.
REQ-026 rst mid-operation SHALL abandon the transaction with no response produced.

Structure
REQ-027 Package alu_seq_pkg SHALL hold the in_op enum, state enum, ALU mode/opcode constants, flag bit indices.
REQ-028 No sub-module; ALU instantiated by parent; flag computation SHALL be a package function.

Verification
REQ-029 ADD16 0x00FF+0x0001 -> FIX taken, 0x0100, flags Z0 C0 S0 V0, out_valid 3 cycles after accept.
REQ-030 ADD16 0xFFFF+0x0001 -> 0x0000, Z1 C1; ADD16 0x7FFF+0x0001 -> 0x8000, S1 V1 C0, 3-cycle latency each.
REQ-031 SUB16 0x0100-0x0001 -> 0x00FF, C0; SUB16 0x0000-0x0001 -> 0xFFFF, C1 S1 V0.
REQ-032 XOR16 0xA5A5^0xFFFF -> 0x5A5A, C0 V0, 2-cycle latency, alu_mode=0 alu_op=4 in LO/HI.
REQ-033 out_ready low 5 cycles in DONE -> outputs held, in_ready 0; in_op=7 -> out_err=1 after 1 cycle.
REQ-034 rst asserted in HI -> next cycle IDLE, in_ready 1, out_valid 0, no response emitted.
